// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: select generator for a 2:1 data mux.
//
// Arbitrates between two valid/ready request streams. It registers the
// winning word into a single-entry output stage that has a valid/ready
// handshake. Round-robin fairness limits a source to BURST_LEN consecutive
// grants while the other source is also requesting.
//
// Optional feature macro: MUX_RR_ARBITER_LOCK_EN adds the `lock` input. When
// lock is high, the current owner keeps priority regardless of burst count.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   din_0/req_0/ack_0     source 0 data, valid, accept (ack is combinational)
//   din_1/req_1/ack_1     source 1 data, valid, accept (ack is combinational)
//   lock                  (macro only) hold priority with the current owner
//   sel                   registered mux select, last granted source
//   dout/dout_valid       registered output word and its valid
//   dout_ready            downstream accepts dout this cycle
module mux_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] din_0,
  input  logic                  req_0,
  output logic                  ack_0,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic                  req_1,
  output logic                  ack_1,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic                  lock,
`endif
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_burst_cnt;
  logic                    r_sel;
  logic                    r_dout_valid;
  logic [DATA_WIDTH-1:0]   r_dout;

  logic                    w_load;
  logic                    w_both;
  logic                    w_owner;
  logic                    w_lock;
  logic                    w_keep;
  logic                    w_grant;
  logic                    w_gsel;
  logic                    w_same_owner;
  logic [CNT_W-1:0]        w_cnt_next;

`ifdef MUX_RR_ARBITER_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Grant decode: pick the winner and drive the same-cycle acks.
  always_comb begin
    w_load       = !r_dout_valid || dout_ready;
    w_both       = req_0 && req_1;
    w_owner      = (r_state == ST_OWN1);
    w_keep       = (r_burst_cnt < BURST_LIM) || w_lock;
    w_grant      = w_load && (req_0 || req_1) && reset_n;
    w_gsel       = 1'b0;
    if (!w_both) begin
      w_gsel = req_1;
    end else if (r_state == ST_IDLE) begin
      w_gsel = 1'b0;
    end else begin
      w_gsel = w_keep ? w_owner : !w_owner;
    end
    ack_0        = w_grant && !w_gsel;
    ack_1        = w_grant && w_gsel;
    w_same_owner = ((r_state == ST_OWN0) && !w_gsel) ||
                   ((r_state == ST_OWN1) && w_gsel);
    // The count only grows under contention, so solo streams never force a switch.
    w_cnt_next   = '0;
    if (w_both && w_same_owner) begin
      w_cnt_next = (r_burst_cnt == CNT_MAX) ? CNT_MAX : r_burst_cnt + CNT_W'(1);
    end
  end

  // Ownership state, burst counter and the registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_burst_cnt  <= '0;
      r_sel        <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
    end else if (w_load) begin
      if (w_grant) begin
        r_state      <= w_gsel ? ST_OWN1 : ST_OWN0;
        r_burst_cnt  <= w_cnt_next;
        r_sel        <= w_gsel;
        r_dout_valid <= 1'b1;
        r_dout       <= w_gsel ? din_1 : din_0;
      end else begin
        r_state      <= ST_IDLE;
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter. Directed scenarios pin literal values.
// A randomized valid/ready run is then checked each cycle against a
// behavioural ownership/streak model.
module tb_mux_rr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] din_0, din_1, dout;
  logic          req_0, req_1, ack_0, ack_1, sel, dout_valid, dout_ready;
`ifdef MUX_RR_ARBITER_LOCK_EN
  logic          lock;
`endif

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n),
    .din_0(din_0), .req_0(req_0), .ack_0(ack_0),
    .din_1(din_1), .req_1(req_1), .ack_1(ack_1),
`ifdef MUX_RR_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .sel(sel), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: held word, last owner (-1 = none), contested-streak length.
  bit            m_valid;
  logic [DW-1:0] m_dout;
  bit            m_sel;
  int            m_owner;
  int            m_streak;
  bit            a0_s, a1_s;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_dout = '0; m_sel = 0; m_owner = -1; m_streak = 0;
  endtask

  // Winner this cycle from the round-robin rules, -1 for no grant.
  function automatic int exp_grant();
    bit lk;
    lk = 0;
`ifdef MUX_RR_ARBITER_LOCK_EN
    lk = lock;
`endif
    if (!reset_n) return -1;
    if (m_valid && !dout_ready) return -1;
    if (!req_0 && !req_1) return -1;
    if (req_0 != req_1) return req_1 ? 1 : 0;
    if (m_owner < 0) return 0;
    if (lk || m_streak < int'(BL) - 1) return m_owner;
    return 1 - m_owner;
  endfunction

  task automatic model_update();
    int g;
    bit other;
    if (!reset_n) begin
      model_reset();
    end else begin
      g = exp_grant();
      if (g >= 0) begin
        other = (g == 0) ? req_1 : req_0;
        if (other && g == m_owner) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        else m_streak = 0;
        m_owner = g;
        m_valid = 1;
        m_dout  = (g == 1) ? din_1 : din_0;
        m_sel   = (g == 1);
      end else if (!m_valid || dout_ready) begin
        m_valid = 0;
        m_owner = -1;
      end
    end
  endtask

  task automatic check_all();
    int g;
    g = exp_grant();
    cmp("ack_0", 32'(ack_0), 32'(g == 0));
    cmp("ack_1", 32'(ack_1), 32'(g == 1));
    cmp("dout_valid", 32'(dout_valid), 32'(m_valid));
    cmp("dout", 32'(dout), 32'(m_dout));
    cmp("sel", 32'(sel), 32'(m_sel));
    a0_s = ack_0;
    a1_s = ack_1;
  endtask

  // One cycle: inputs are already set at the negedge. Checks, then advances the model.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic advance_data();
    if (a0_s) din_0 = din_0 + 8'd1;
    if (a1_s) din_1 = din_1 + 8'd1;
  endtask

  logic pat [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic pat2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset_n = 0; model_reset();
    req_0 = 1; req_1 = 1; din_0 = 8'hA0; din_1 = 8'hB0; dout_ready = 1;
`ifdef MUX_RR_ARBITER_LOCK_EN
    lock = 0;
`endif
    a0_s = 0; a1_s = 0;
    @(negedge clk);
    #1 cmp("rst_acks", 32'(ack_0 | ack_1), 32'd0);
    cmp("rst_valid", 32'(dout_valid), 32'd0);
    repeat (2) tick();

    // Release with both requesting: the burst-limited alternation.
    reset_n = 1;
    for (int i = 0; i < 9; i++) begin
      #1 cmp("pat_ack1", 32'(ack_1), 32'(pat[i]));
      if (i == 1) begin
        cmp("first_word", 32'(dout), 32'hA0);
        cmp("first_sel", 32'(sel), 32'd0);
      end
      tick();
      advance_data();
    end

    // Solo source 1: no forced switch.
    req_0 = 0; req_1 = 1;
    for (int i = 0; i < 10; i++) begin
      #1 cmp("solo_ack1", 32'(ack_1), 32'd1);
      tick();
      advance_data();
    end

    // Output stall: no acks and a stable output.
    req_0 = 1; dout_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 cmp("stall_acks", 32'(ack_0 | ack_1), 32'd0);
      cmp("stall_sel", 32'(sel), 32'd1);
      tick();
    end
    // Streak stayed at zero during the solo run, so source 1 keeps three more grants.
    dout_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 cmp("resume_ack1", 32'(ack_1), 32'(pat2[i]));
      tick();
      advance_data();
    end

    // Idle gap: valid drops, then source 0 wins the simultaneous request.
    req_0 = 0; req_1 = 0;
    tick();
    req_0 = 1; req_1 = 1;
    #1 cmp("idle_valid", 32'(dout_valid), 32'd0);
    cmp("idle_ack0", 32'(ack_0), 32'd1);
    tick();
    advance_data();

    // Randomized valid/ready traffic with one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      if (!(req_0 && !a0_s)) begin req_0 = ($urandom_range(0, 3) != 0); din_0 = 8'($urandom); end
      if (!(req_1 && !a1_s)) begin req_1 = ($urandom_range(0, 3) != 0); din_1 = 8'($urandom); end
      dout_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_ARBITER_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      if (c == 1500 || c == 1501) begin
        reset_n = 0;
        model_reset();
      end else begin
        reset_n = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Upstream select-generation stage for the 2:1 data mux. It arbitrates between two valid/ready request streams and drives the mux select. It registers the winning word into a single-entry output stage with a valid/ready handshake. Round-robin fairness has a bounded burst length, so one source cannot starve the other.

Parameters:
DATA_WIDTH, 8, width of din_0, din_1 and dout
BURST_LEN, 4, maximum consecutive grants to one source while the other requests (range 1..15)

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous active-low reset
din_0  input  DATA_WIDTH  source 0 data
req_0  input  1  source 0 valid
ack_0  output  1  source 0 accepted this cycle (combinational)
din_1  input  DATA_WIDTH  source 1 data
req_1  input  1  source 1 valid
ack_1  output  1  source 1 accepted this cycle (combinational)
sel  output  1  registered mux select: 0 = din_0, 1 = din_1; last granted source
dout  output  DATA_WIDTH  registered output data
dout_valid  output  1  output register holds a word
dout_ready  input  1  downstream accepts dout this cycle

Behaviour:
- Reset (reset_n low, asynchronous): dout_valid=0, dout=0, sel=0, burst_cnt=0, state=IDLE. ack_0 and ack_1 are forced 0 while reset_n is low.
- load = !dout_valid | dout_ready. Arbitration happens only when load=1 and at least one req is high.
- States: IDLE (no grant yet, or last cycle had no request), OWN0 (last grant was source 0), OWN1 (last grant was source 1).
- Grant rules when load=1:
  - Only one req high: that source wins.
  - Both req high in IDLE: source 0 wins.
  - Both req high in OWNx: the owner wins if burst_cnt < BURST_LEN-1; otherwise the other source wins.
- On a grant to source g:
  - ack_g=1 in the same cycle.
  - Next edge: dout<=din_g, dout_valid<=1, sel<=g, state<=OWNg.
  - burst_cnt<=burst_cnt+1 if g equals the previous owner, else burst_cnt<=0.
- burst_cnt is 4 bits and saturates at 15.
- A grant to source g while the other req is low resets burst_cnt to 0. No forced switch is ever required when there is no contention.
- load=1 with no req: dout_valid<=0 and state<=IDLE. sel, dout and burst_cnt hold.
- load=0 (dout_valid=1 and dout_ready=0): no ack, and dout, sel and dout_valid hold. Requests must hold their data until acked.
- Throughput: one word per cycle when dout_ready is held high. Latency from ack to dout_valid is 1 cycle.
- At most one of ack_0/ack_1 is high in any cycle.
- Reset asserted mid-transfer drops the held word. Sources see no ack for it.

Optional Feature:
MUX_RR_ARBITER_LOCK_EN
- With the macro defined: adds input port lock (1 bit). When lock=1 and state is OWNx, the owner keeps priority regardless of burst_cnt, and burst_cnt saturates rather than forcing a switch. If the owner does not request, the other source may still win. Fairness resumes on the first arbitration after lock falls.
- Without the macro: no lock port, and burst limiting always applies.

Test Plan:
1. Reset with req_0=req_1=1, din_0=8'hA0, din_1=8'hB0 held through release, dout_ready=1 -> while reset_n low: acks 0, dout_valid=0. After release: first word A0 with sel=0.
2. Both requesting continuously, BURST_LEN=4, dout_ready=1 -> ack pattern 0,0,0,0,1,1,1,1,0,... and sel tracks the pattern one cycle later.
3. Only req_1 high for 10 cycles -> 10 consecutive B-words, no forced switch, burst_cnt stays 0.
4. dout_valid=1 with dout_ready=0 for 3 cycles and both req high -> no acks, dout and sel stable. On dout_ready=1, the next grant follows round-robin state.
5. Requests drop for 1 cycle with dout_ready=1 -> dout_valid=0 next cycle, state IDLE. Next simultaneous request grants source 0.
6. MUX_RR_ARBITER_LOCK_EN defined, lock=1 while owner is source 0 and both requesting for 8 cycles -> 8 source-0 grants. lock=0 at cycle 9 -> source 1 granted.
